// File: rtl/rcon_sequencer.sv
// AES round-constant sequencer: GF(2^8) doubling (encrypt) or halving (decrypt), one Rcon per i_Next handshake.
// Optional RCON_CHECK_EN adds o_Check_Err, a sticky compare against the standard constant table.
module rcon_sequencer #(
   parameter int          NUM_RCON = 10,
   parameter logic [7:0]  POLY     = 8'h1B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_Start,
   input  logic       i_Decrypt,
   input  logic [1:0] i_Key_Size,
   input  logic       i_Next,
   output logic [7:0] o_Rcon,
   output logic       o_Valid,
   output logic [3:0] o_Round,
   output logic       o_Last,
   output logic       o_Busy,
   output logic       o_Done
`ifdef RCON_CHECK_EN
   ,
   output logic       o_Check_Err
`endif
);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

   localparam logic [3:0] CAP = 4'(NUM_RCON);

   state_t     state, state_nxt;
   logic [7:0] rcon, rcon_nxt;
   logic [3:0] round, round_nxt;
   logic [3:0] num, num_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       dec, dec_nxt;
   logic [3:0] key_num, num_sel;
   logic       last;

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? POLY : 8'h00);
   endfunction

   function automatic logic [7:0] inv_xtime(input logic [7:0] r);
      logic [8:0] t;
      t = ({1'b1, POLY} & {9{r[0]}}) ^ {1'b0, r};
      return t[8:1];
   endfunction

   always_comb begin
      case (i_Key_Size)
         2'b01:   key_num = 4'd8;
         2'b10:   key_num = 4'd7;
         default: key_num = 4'd10;
      endcase
      num_sel = (key_num < CAP) ? key_num : CAP;
   end

   assign last = (state == RUN) && (dec ? (round == 4'd1) : (round == num));

   always_comb begin
      state_nxt = state;
      rcon_nxt  = rcon;
      round_nxt = round;
      num_nxt   = num;
      cnt_nxt   = cnt;
      dec_nxt   = dec;
      if (i_Start) begin
         dec_nxt  = i_Decrypt;
         num_nxt  = num_sel;
         rcon_nxt = 8'h01;
         if (i_Decrypt) begin
            state_nxt = PRIME;
            round_nxt = 4'd0;
            cnt_nxt   = num_sel - 4'd1;
         end else begin
            state_nxt = RUN;
            round_nxt = 4'd1;
            cnt_nxt   = 4'd0;
         end
      end else begin
         case (state)
            // Walk forward to the last constant so the descending run can start from it.
            PRIME: begin
               if (cnt != 4'd0) begin
                  rcon_nxt = xtime(rcon);
                  cnt_nxt  = cnt - 4'd1;
               end
               if (cnt <= 4'd1) begin
                  state_nxt = RUN;
                  round_nxt = num;
               end
            end
            RUN: begin
               if (i_Next) begin
                  if (last) begin
                     state_nxt = DONE;
                  end else if (dec) begin
                     rcon_nxt  = inv_xtime(rcon);
                     round_nxt = round - 4'd1;
                  end else begin
                     rcon_nxt  = xtime(rcon);
                     round_nxt = round + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rcon  <= 8'h00;
         round <= 4'd0;
         num   <= 4'd0;
         cnt   <= 4'd0;
         dec   <= 1'b0;
      end else begin
         state <= state_nxt;
         rcon  <= rcon_nxt;
         round <= round_nxt;
         num   <= num_nxt;
         cnt   <= cnt_nxt;
         dec   <= dec_nxt;
      end
   end

   assign o_Rcon  = rcon;
   assign o_Round = round;
   assign o_Valid = (state == RUN);
   assign o_Last  = last;
   assign o_Busy  = (state == PRIME) || (state == RUN);
   assign o_Done  = (state == DONE);

`ifdef RCON_CHECK_EN
   logic chk_err;
   logic chk_mis;

   function automatic logic [7:0] ref_rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1B;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // The table only describes the standard polynomial and rounds 1..10.
   assign chk_mis = o_Valid && (POLY == 8'h1B) && (round >= 4'd1) && (round <= 4'd10)
                    && (rcon != ref_rcon(round));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       chk_err <= 1'b0;
      else if (i_Start) chk_err <= 1'b0;
      else if (chk_mis) chk_err <= 1'b1;
   end

   assign o_Check_Err = chk_err;
`endif

endmodule

// File: tb/tb_rcon_sequencer.sv
// Directed bench for rcon_sequencer: two instances share stimulus, the second capped at NUM_RCON=4.
module tb_rcon_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, dec, nxt;
   logic [1:0] ks;

   logic [7:0] rcon_a, rcon_b;
   logic [3:0] round_a, round_b;
   logic       valid_a, last_a, busy_a, done_a;
   logic       valid_b, last_b, busy_b, done_b;
`ifdef RCON_CHECK_EN
   logic       err_a, err_b;
`endif

   int errors = 0;
   int checks = 0;
   int k;

   logic [7:0] exp_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

   always #5 clk = ~clk;

   rcon_sequencer #(.NUM_RCON(10), .POLY(8'h1B)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_Start(start), .i_Decrypt(dec), .i_Key_Size(ks), .i_Next(nxt),
      .o_Rcon(rcon_a), .o_Valid(valid_a), .o_Round(round_a), .o_Last(last_a),
      .o_Busy(busy_a), .o_Done(done_a)
`ifdef RCON_CHECK_EN
      , .o_Check_Err(err_a)
`endif
   );

   rcon_sequencer #(.NUM_RCON(4), .POLY(8'h1B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_Start(start), .i_Decrypt(dec), .i_Key_Size(ks), .i_Next(nxt),
      .o_Rcon(rcon_b), .o_Valid(valid_b), .o_Round(round_b), .o_Last(last_b),
      .o_Busy(busy_b), .o_Done(done_b)
`ifdef RCON_CHECK_EN
      , .o_Check_Err(err_b)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 2 time units after each rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start(input logic d, input logic [1:0] size, input logic n);
      start = 1'b1; dec = d; ks = size; nxt = n;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; dec = 1'b0; ks = 2'b00; nxt = 1'b0;
      #12;
      chk("rst_rcon", 16'(rcon_a), 16'h00);
      chk("rst_valid", 16'(valid_a), 16'h0);
      chk("rst_round", 16'(round_a), 16'h0);
      chk("rst_last", 16'(last_a), 16'h0);
      chk("rst_busy", 16'(busy_a), 16'h0);
      chk("rst_done", 16'(done_a), 16'h0);
      rst_n = 1'b1;
      cyc();

      // AES-128 encrypt, next held high
      pulse_start(1'b0, 2'b00, 1'b1);
      for (int i = 0; i < 10; i++) begin
         chk("e128_rcon", 16'(rcon_a), 16'(exp_tab[i]));
         chk("e128_round", 16'(round_a), 16'(i + 1));
         chk("e128_valid", 16'(valid_a), 16'h1);
         chk("e128_last", 16'(last_a), 16'(i == 9));
         cyc();
      end
      chk("e128_done", 16'(done_a), 16'h1);
      chk("e128_done_valid", 16'(valid_a), 16'h0);
      chk("e128_done_rcon", 16'(rcon_a), 16'h36);
      cyc();
      chk("e128_done_hold", 16'(done_a), 16'h1);
      chk("e128_done_busy", 16'(busy_a), 16'h0);
`ifdef RCON_CHECK_EN
      chk("e128_chk_err", 16'(err_a), 16'h0);
`endif

      // AES-128 decrypt: priming then descending order
      pulse_start(1'b1, 2'b00, 1'b0);
      chk("d128_prime_valid", 16'(valid_a), 16'h0);
      chk("d128_prime_busy", 16'(busy_a), 16'h1);
      chk("d128_done_clr", 16'(done_a), 16'h0);
      k = 0;
      while (!valid_a && k < 20) begin
         cyc();
         k++;
      end
      chk("d128_latency", 16'(k), 16'd9);
      nxt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("d128_rcon", 16'(rcon_a), 16'(exp_tab[9 - i]));
         chk("d128_round", 16'(round_a), 16'(10 - i));
         chk("d128_last", 16'(last_a), 16'(i == 9));
         cyc();
      end
      chk("d128_done", 16'(done_a), 16'h1);
      chk("d128_done_rcon", 16'(rcon_a), 16'h01);
`ifdef RCON_CHECK_EN
      chk("d128_chk_err", 16'(err_a), 16'h0);
`endif

      // AES-256 encrypt, next on every third cycle
      pulse_start(1'b0, 2'b10, 1'b0);
      for (int i = 0; i < 7; i++) begin
         for (int c = 0; c < 3; c++) begin
            nxt = (c == 2);
            chk("e256_rcon", 16'(rcon_a), 16'(exp_tab[i]));
            chk("e256_round", 16'(round_a), 16'(i + 1));
            chk("e256_last", 16'(last_a), 16'(i == 6));
            cyc();
         end
      end
      chk("e256_done", 16'(done_a), 16'h1);
      chk("e256_done_rcon", 16'(rcon_a), 16'h40);

      // AES-192 encrypt: 8 constants, capped to 4 on the second instance
      pulse_start(1'b0, 2'b01, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("e192_rcon", 16'(rcon_a), 16'(exp_tab[i]));
         chk("e192_last", 16'(last_a), 16'(i == 7));
         if (i < 4) begin
            chk("cap4_rcon", 16'(rcon_b), 16'(exp_tab[i]));
            chk("cap4_last", 16'(last_b), 16'(i == 3));
         end
         if (i == 4) begin
            chk("cap4_done", 16'(done_b), 16'h1);
            chk("cap4_done_rcon", 16'(rcon_b), 16'h08);
         end
         cyc();
      end
      chk("e192_done", 16'(done_a), 16'h1);

      // Restart at round 5 with i_Next also high; key size 11 acts as 128
      pulse_start(1'b0, 2'b11, 1'b1);
      for (int i = 0; i < 4; i++) cyc();
      chk("rs_pre_rcon", 16'(rcon_a), 16'h10);
      chk("rs_pre_round", 16'(round_a), 16'd5);
      pulse_start(1'b0, 2'b11, 1'b1);
      for (int i = 0; i < 10; i++) begin
         chk("rs_rcon", 16'(rcon_a), 16'(exp_tab[i]));
         chk("rs_round", 16'(round_a), 16'(i + 1));
         chk("rs_last", 16'(last_a), 16'(i == 9));
         cyc();
      end
      chk("rs_done", 16'(done_a), 16'h1);
`ifdef RCON_CHECK_EN
      chk("rs_chk_err", 16'(err_a), 16'h0);
      chk("cap4_chk_err", 16'(err_b), 16'h0);
`endif

      // Asynchronous reset in the middle of priming
      nxt = 1'b0;
      pulse_start(1'b1, 2'b00, 1'b0);
      cyc();
      cyc();
      chk("mid_prime_busy", 16'(busy_a), 16'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_rcon", 16'(rcon_a), 16'h00);
      chk("arst_busy", 16'(busy_a), 16'h0);
      chk("arst_round", 16'(round_a), 16'h0);
      chk("arst_valid", 16'(valid_a), 16'h0);
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      chk("post_rst_busy", 16'(busy_a), 16'h0);
      chk("post_rst_valid", 16'(valid_a), 16'h0);
      chk("post_rst_done", 16'(done_a), 16'h0);
      chk("post_rst_rcon", 16'(rcon_a), 16'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
